// File: rtl/img_read_requester.sv
// ---------------------------------------------------------------------------
// img_read_requester
//
// Requesting end of one image read port of the memory pool. A burst command
// (group, bank mask, base address, stride, length) is turned into a sequence
// of bank read requests. Data returned by the pool is collected in a small
// ordered FIFO and presented as a valid/ready stream with a last marker.
//
// Requests are only issued while the FIFO is guaranteed to have room for
// every beat that can still come back, so the return side never needs to
// backpressure the pool.
//
// Ports
//   clk, rst_n               clock, synchronous active-low reset
//   cmd_*                    burst command handshake and fields
//   read_group_id_o          one-hot group of the current request
//   read_bank_en_o           per-bank request strobe (nonzero = request)
//   read_addr_o              per-bank address, zero in disabled slots
//   read_addr_ready_i        pool accepts the current request
//   read_data_valid_i/_i     returned data from the pool
//   read_data_ready_o        high whenever a burst is in progress
//   out_valid_o/_data_o      output stream (FIFO head)
//   out_last_o               head entry is the final beat of the burst
//   out_ready_i              stream consumer ready
//   done_o                   one-cycle pulse when the burst has completed
//   err_o                    sticky: data returned with nothing outstanding
// ---------------------------------------------------------------------------
module img_read_requester #(
    parameter int IMG_GRP_NUM     = 3,
    parameter int ROW_PARA        = 4,
    parameter int CHL_PARA        = 8,
    parameter int BANK_ADDR_WIDTH = 12,
    parameter int BANK_UNIT_WIDTH = 8,
    parameter int LEN_WIDTH       = 12,
    parameter int FIFO_DEPTH      = 4
) (
    input  logic                                         clk,
    input  logic                                         rst_n,
    input  logic                                         cmd_valid_i,
    output logic                                         cmd_ready_o,
    input  logic [IMG_GRP_NUM-1:0]                       cmd_group_id_i,
    input  logic [ROW_PARA-1:0]                          cmd_bank_en_i,
    input  logic [BANK_ADDR_WIDTH-1:0]                   cmd_base_addr_i,
    input  logic [BANK_ADDR_WIDTH-1:0]                   cmd_stride_i,
    input  logic [LEN_WIDTH-1:0]                         cmd_len_i,
    output logic [IMG_GRP_NUM-1:0]                       read_group_id_o,
    output logic [ROW_PARA-1:0]                          read_bank_en_o,
    output logic [ROW_PARA*BANK_ADDR_WIDTH-1:0]          read_addr_o,
    input  logic                                         read_addr_ready_i,
    input  logic                                         read_data_valid_i,
    input  logic [ROW_PARA*BANK_UNIT_WIDTH*CHL_PARA-1:0] read_data_i,
    output logic                                         read_data_ready_o,
    output logic                                         out_valid_o,
    output logic [ROW_PARA*BANK_UNIT_WIDTH*CHL_PARA-1:0] out_data_o,
    output logic                                         out_last_o,
    input  logic                                         out_ready_i,
    output logic                                         done_o,
    output logic                                         err_o
);

    localparam int DATA_WIDTH = ROW_PARA * BANK_UNIT_WIDTH * CHL_PARA;
    localparam int PTR_WIDTH  = $clog2(FIFO_DEPTH);
    localparam int CNT_WIDTH  = PTR_WIDTH + 1;
    localparam int SUM_WIDTH  = LEN_WIDTH + 1;

    localparam logic [LEN_WIDTH-1:0] LEN_ONE = LEN_WIDTH'(1);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ISSUE = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;

    logic [1:0]                 state;
    logic [IMG_GRP_NUM-1:0]     group_q;
    logic [ROW_PARA-1:0]        mask_q;
    logic [BANK_ADDR_WIDTH-1:0] stride_q;
    logic [BANK_ADDR_WIDTH-1:0] cur_addr;
    logic [LEN_WIDTH-1:0]       len_q;
    logic [LEN_WIDTH-1:0]       issued;
    logic [LEN_WIDTH-1:0]       returned;
    logic [LEN_WIDTH-1:0]       popped;
    logic                       zero_done_q;
    logic                       err_q;
    logic                       ignore_late_q;

    logic [DATA_WIDTH-1:0]      fifo_mem [FIFO_DEPTH];
    logic [PTR_WIDTH-1:0]       wr_ptr;
    logic [PTR_WIDTH-1:0]       rd_ptr;
    logic [CNT_WIDTH-1:0]       fifo_count;

    logic                       cmd_fire;
    logic [LEN_WIDTH-1:0]       outstanding;
    logic [SUM_WIDTH-1:0]       in_use;
    logic                       credit_ok;
    logic                       req_active;
    logic                       req_fire;
    logic                       zero_accept;
    logic                       req_last;
    logic                       have_outstanding;
    logic                       data_capture;
    logic                       spurious;
    logic                       push;
    logic                       fifo_empty;
    logic                       pop;
    logic                       head_is_last;
    logic                       final_pop;

    assign cmd_fire = (state == ST_IDLE) && cmd_valid_i;

    // Every beat either sits in the FIFO or is still in flight in the pool;
    // a new request is allowed only while the sum leaves a free FIFO slot.
    assign outstanding = issued - returned;
    assign in_use      = {1'b0, outstanding}
                       + {{(SUM_WIDTH-CNT_WIDTH){1'b0}}, fifo_count};
    assign credit_ok   = in_use < SUM_WIDTH'(FIFO_DEPTH);

    assign req_active  = (state == ST_ISSUE) && credit_ok;

    // A zero bank mask never reaches the pool: the beat is taken as accepted
    // at once and read_data_i is stored as its data.
    assign zero_accept = req_active && (mask_q == '0);
    assign req_fire    = req_active && ((mask_q == '0) || read_addr_ready_i);
    assign req_last    = (issued == len_q - LEN_ONE);

    assign have_outstanding = (issued != returned);
    assign data_capture     = read_data_valid_i && (state != ST_IDLE)
                            && have_outstanding;

    // After a reset the pool may still answer requests of the aborted burst;
    // those are ignored in IDLE until the next command is taken.
    assign spurious = read_data_valid_i
                    && ((state == ST_IDLE) ? !ignore_late_q : !have_outstanding);

    assign push         = data_capture || zero_accept;
    assign fifo_empty   = (fifo_count == '0);
    assign pop          = !fifo_empty && out_ready_i;
    assign head_is_last = (state != ST_IDLE) && (popped == len_q - LEN_ONE);
    assign final_pop    = (state == ST_DRAIN) && pop && head_is_last;

    // Outputs are forced low whenever reset is asserted.
    assign cmd_ready_o       = rst_n && (state == ST_IDLE);
    assign read_group_id_o   = (rst_n && req_active) ? group_q : '0;
    assign read_bank_en_o    = (rst_n && req_active) ? mask_q  : '0;
    assign read_data_ready_o = rst_n && (state != ST_IDLE);
    assign out_valid_o       = rst_n && !fifo_empty;
    assign out_data_o        = rst_n ? fifo_mem[rd_ptr] : '0;
    assign out_last_o        = rst_n && !fifo_empty && head_is_last;
    assign done_o            = rst_n && (zero_done_q || final_pop);
    assign err_o             = rst_n && err_q;

    // Enabled bank slots carry the current address, disabled slots are 0.
    always_comb begin
        read_addr_o = '0;
        for (int i = 0; i < ROW_PARA; i++) begin
            if (rst_n && req_active && mask_q[i]) begin
                read_addr_o[i*BANK_ADDR_WIDTH +: BANK_ADDR_WIDTH] = cur_addr;
            end
        end
    end

    // Burst control: command capture, address walk and state sequencing.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state         <= ST_IDLE;
            group_q       <= '0;
            mask_q        <= '0;
            stride_q      <= '0;
            cur_addr      <= '0;
            len_q         <= '0;
            zero_done_q   <= 1'b0;
            ignore_late_q <= 1'b1;
        end else begin
            zero_done_q <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (cmd_valid_i) begin
                        group_q       <= cmd_group_id_i;
                        mask_q        <= cmd_bank_en_i;
                        stride_q      <= cmd_stride_i;
                        cur_addr      <= cmd_base_addr_i;
                        len_q         <= cmd_len_i;
                        ignore_late_q <= 1'b0;
                        if (cmd_len_i == '0) begin
                            zero_done_q <= 1'b1;
                        end else begin
                            state <= ST_ISSUE;
                        end
                    end
                end
                ST_ISSUE: begin
                    if (req_fire) begin
                        cur_addr <= cur_addr + stride_q;
                        if (req_last) begin
                            state <= ST_DRAIN;
                        end
                    end
                end
                ST_DRAIN: begin
                    if (final_pop) begin
                        state <= ST_IDLE;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    // Beat counters for requests, returns and stream pops, plus the error flag.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            issued   <= '0;
            returned <= '0;
            popped   <= '0;
            err_q    <= 1'b0;
        end else begin
            if (cmd_fire) begin
                issued   <= '0;
                returned <= '0;
                popped   <= '0;
            end else begin
                if (req_fire) begin
                    issued <= issued + LEN_ONE;
                end
                if (push) begin
                    returned <= returned + LEN_ONE;
                end
                if (pop) begin
                    popped <= popped + LEN_ONE;
                end
            end
            if (spurious) begin
                err_q <= 1'b1;
            end
        end
    end

    // Return FIFO pointers and occupancy.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_WIDTH'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_WIDTH'(1);
            end
            case ({push, pop})
                2'b10:   fifo_count <= fifo_count + CNT_WIDTH'(1);
                2'b01:   fifo_count <= fifo_count - CNT_WIDTH'(1);
                default: fifo_count <= fifo_count;
            endcase
        end
    end

    // Return FIFO storage; contents need no reset since occupancy is cleared.
    always_ff @(posedge clk) begin
        if (rst_n && push) begin
            fifo_mem[wr_ptr] <= read_data_i;
        end
    end

endmodule

// File: tb/tb_img_read_requester.sv
// ---------------------------------------------------------------------------
// tb_img_read_requester
//
// Drives burst commands into img_read_requester while a pool/sink agent
// answers requests with random data after a configurable latency and
// consumes the output stream. Expected addresses and stream contents come
// from a reference model built from the burst parameters.
// ---------------------------------------------------------------------------
module tb_img_read_requester;

    localparam int GRP  = 3;
    localparam int RP   = 4;
    localparam int AW   = 12;
    localparam int LW   = 12;
    localparam int DEP  = 4;
    localparam int DW   = 256;

    logic               clk;
    logic               rst_n;
    logic               cmd_valid_i;
    logic               cmd_ready_o;
    logic [GRP-1:0]     cmd_group_id_i;
    logic [RP-1:0]      cmd_bank_en_i;
    logic [AW-1:0]      cmd_base_addr_i;
    logic [AW-1:0]      cmd_stride_i;
    logic [LW-1:0]      cmd_len_i;
    logic [GRP-1:0]     read_group_id_o;
    logic [RP-1:0]      read_bank_en_o;
    logic [RP*AW-1:0]   read_addr_o;
    logic               read_addr_ready_i;
    logic               read_data_valid_i;
    logic [DW-1:0]      read_data_i;
    logic               read_data_ready_o;
    logic               out_valid_o;
    logic [DW-1:0]      out_data_o;
    logic               out_last_o;
    logic               out_ready_i;
    logic               done_o;
    logic               err_o;

    img_read_requester dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .cmd_valid_i       (cmd_valid_i),
        .cmd_ready_o       (cmd_ready_o),
        .cmd_group_id_i    (cmd_group_id_i),
        .cmd_bank_en_i     (cmd_bank_en_i),
        .cmd_base_addr_i   (cmd_base_addr_i),
        .cmd_stride_i      (cmd_stride_i),
        .cmd_len_i         (cmd_len_i),
        .read_group_id_o   (read_group_id_o),
        .read_bank_en_o    (read_bank_en_o),
        .read_addr_o       (read_addr_o),
        .read_addr_ready_i (read_addr_ready_i),
        .read_data_valid_i (read_data_valid_i),
        .read_data_i       (read_data_i),
        .read_data_ready_o (read_data_ready_o),
        .out_valid_o       (out_valid_o),
        .out_data_o        (out_data_o),
        .out_last_o        (out_last_o),
        .out_ready_i       (out_ready_i),
        .done_o            (done_o),
        .err_o             (err_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int            due;
        logic [DW-1:0] data;
    } ret_t;

    int checkCount = 0;
    int passCount  = 0;
    int failCount  = 0;

    int cycleNo       = 0;
    int addrReadyMode = 0;
    int outReadyMode  = 0;
    int poolLat       = 2;
    int lastDue       = 0;
    bit spuriousReq   = 1'b0;

    bit            burstActive = 1'b0;
    int            curLen      = 0;
    int            beatIdx     = 0;
    int            reqCount    = 0;
    int            popCount    = 0;
    int            doneCount   = 0;
    int            doneAtStart = 0;
    logic [GRP-1:0] expGrp     = '0;
    logic [RP-1:0]  expMask    = '0;
    int            expAddr[$];
    logic [DW-1:0] expData[$];
    ret_t          pending[$];

    // Every comparison goes through here and steps the pass/total counters.
    task automatic checkOutput(input string tag, input logic [DW-1:0] observed,
                               input logic [DW-1:0] expected);
        checkCount++;
        assert (observed === expected) begin
            passCount++;
        end else begin
            failCount++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    function automatic logic [DW-1:0] randData();
        logic [DW-1:0] d;
        for (int i = 0; i < DW / 32; i++) begin
            d[i*32 +: 32] = $urandom;
        end
        return d;
    endfunction

    task automatic waitCycles(input int n);
        repeat (n) @(negedge clk);
        #1;
    endtask

    // Pool and stream-sink agent: observes handshakes at the falling edge,
    // then drives the next cycle's inputs just after the rising edge.
    initial begin : agent
        logic [RP*AW-1:0] expSlots;
        bit               popNow;
        int               due;
        ret_t             r;
        read_addr_ready_i = 1'b0;
        read_data_valid_i = 1'b0;
        read_data_i       = '0;
        out_ready_i       = 1'b0;
        forever begin
            @(negedge clk);
            cycleNo++;
            if (rst_n) begin
                popNow = out_valid_o && out_ready_i;
                if (read_bank_en_o != '0) begin
                    checkOutput("request_expected", DW'(expAddr.size() != 0), DW'(1'b1));
                    if (expAddr.size() != 0) begin
                        checkOutput("req_group", DW'(read_group_id_o), DW'(expGrp));
                        checkOutput("req_mask", DW'(read_bank_en_o), DW'(expMask));
                        expSlots = '0;
                        for (int i = 0; i < RP; i++) begin
                            if (expMask[i]) expSlots[i*AW +: AW] = AW'(expAddr[0]);
                        end
                        checkOutput("req_addr", DW'(read_addr_o), DW'(expSlots));
                        if (read_addr_ready_i) begin
                            checkOutput("credit_limit", DW'((reqCount - popCount) < DEP), DW'(1'b1));
                            void'(expAddr.pop_front());
                            reqCount++;
                            due = cycleNo + ((poolLat > 0) ? poolLat : int'($urandom_range(1, 5)));
                            if (due <= lastDue) due = lastDue + 1;
                            lastDue = due;
                            r.due  = due;
                            r.data = randData();
                            pending.push_back(r);
                        end
                    end
                end
                if (popNow) begin
                    checkOutput("beat_expected", DW'(expData.size() != 0), DW'(1'b1));
                    if (expData.size() != 0) begin
                        checkOutput("out_data", out_data_o, expData.pop_front());
                        checkOutput("out_last", DW'(out_last_o), DW'(beatIdx == curLen - 1));
                    end
                    beatIdx++;
                    popCount++;
                end
                if ((popNow || done_o) && burstActive && curLen != 0) begin
                    checkOutput("done_at_final_pop", DW'(done_o), DW'(popNow && beatIdx == curLen));
                end
                if (done_o) doneCount++;
            end
            @(posedge clk);
            #1;
            case (addrReadyMode)
                0:       read_addr_ready_i = 1'b1;
                1:       read_addr_ready_i = ~read_addr_ready_i;
                default: read_addr_ready_i = 1'($urandom_range(0, 1));
            endcase
            case (outReadyMode)
                0:       out_ready_i = 1'b1;
                1:       out_ready_i = 1'($urandom_range(0, 1));
                default: out_ready_i = 1'b0;
            endcase
            if (spuriousReq) begin
                read_data_valid_i = 1'b1;
                read_data_i       = randData();
                spuriousReq       = 1'b0;
            end else if (pending.size() != 0 && pending[0].due <= cycleNo + 1) begin
                r = pending.pop_front();
                read_data_valid_i = 1'b1;
                read_data_i       = r.data;
                if (burstActive) expData.push_back(r.data);
            end else begin
                read_data_valid_i = 1'b0;
                read_data_i       = randData();
            end
        end
    end

    // Issues one command and loads the reference model at the accepting edge.
    task automatic applyStimulus(input logic [GRP-1:0] grp, input logic [RP-1:0] mask,
                                 input int base, input int stride, input int len);
        int n = 0;
        cmd_group_id_i  = grp;
        cmd_bank_en_i   = mask;
        cmd_base_addr_i = AW'(base);
        cmd_stride_i    = AW'(stride);
        cmd_len_i       = LW'(len);
        cmd_valid_i     = 1'b1;
        while (!cmd_ready_o && n < 100) begin
            waitCycles(1);
            n++;
        end
        checkOutput("cmd_accepted", DW'(cmd_ready_o), DW'(1'b1));
        expGrp  = grp;
        expMask = mask;
        expAddr.delete();
        expData.delete();
        for (int k = 0; k < len; k++) expAddr.push_back((base + k * stride) % 4096);
        curLen      = len;
        beatIdx     = 0;
        reqCount    = 0;
        popCount    = 0;
        doneAtStart = doneCount;
        burstActive = 1'b1;
        @(posedge clk);
        #1;
        cmd_valid_i = 1'b0;
    endtask

    task automatic waitDone(input int budget);
        int n = 0;
        while (doneCount == doneAtStart && n < budget) begin
            waitCycles(1);
            n++;
        end
        checkOutput("done_within_budget", DW'(n < budget), DW'(1'b1));
        waitCycles(4);
        checkOutput("done_pulse_count", DW'(doneCount - doneAtStart), DW'(1));
        checkOutput("beats_out", DW'(popCount), DW'(curLen));
        checkOutput("requests_accepted", DW'(reqCount), DW'(curLen));
        checkOutput("leftover_data", DW'(expData.size()), DW'(0));
        checkOutput("err_clear", DW'(err_o), DW'(1'b0));
        burstActive = 1'b0;
    endtask

    task automatic runBurst(input logic [GRP-1:0] grp, input logic [RP-1:0] mask,
                            input int base, input int stride, input int len);
        applyStimulus(grp, mask, base, stride, len);
        waitDone(600);
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, "_cmd_ready"}, DW'(cmd_ready_o), '0);
        checkOutput({tag, "_group"}, DW'(read_group_id_o), '0);
        checkOutput({tag, "_bank_en"}, DW'(read_bank_en_o), '0);
        checkOutput({tag, "_addr"}, DW'(read_addr_o), '0);
        checkOutput({tag, "_data_ready"}, DW'(read_data_ready_o), '0);
        checkOutput({tag, "_out_valid"}, DW'(out_valid_o), '0);
        checkOutput({tag, "_out_data"}, out_data_o, '0);
        checkOutput({tag, "_out_last"}, DW'(out_last_o), '0);
        checkOutput({tag, "_done"}, DW'(done_o), '0);
        checkOutput({tag, "_err"}, DW'(err_o), '0);
    endtask

    // Directed sequence of scenarios followed by randomized bursts.
    initial begin : main
        int n;
        rst_n           = 1'b0;
        cmd_valid_i     = 1'b0;
        cmd_group_id_i  = '0;
        cmd_bank_en_i   = '0;
        cmd_base_addr_i = '0;
        cmd_stride_i    = '0;
        cmd_len_i       = '0;
        waitCycles(3);
        checkAllZero("reset");
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        waitCycles(1);
        checkOutput("idle_cmd_ready", DW'(cmd_ready_o), DW'(1'b1));

        $display("[TB] basic burst");
        addrReadyMode = 0; outReadyMode = 0; poolLat = 2;
        runBurst(3'b010, 4'b1111, 'h010, 1, 4);

        $display("[TB] credit stall");
        outReadyMode = 2;
        applyStimulus(3'b001, 4'b1111, 'h100, 2, 8);
        waitCycles(30);
        checkOutput("stall_requests", DW'(reqCount), DW'(DEP));
        checkOutput("stall_bank_en", DW'(read_bank_en_o), '0);
        outReadyMode = 0;
        waitDone(600);

        $display("[TB] address wrap, partial mask");
        runBurst(3'b100, 4'b0101, 'hFFE, 1, 3);

        $display("[TB] address-ready toggling");
        addrReadyMode = 1; poolLat = 0;
        runBurst(3'b010, 4'b1011, 'h123, 3, 6);

        $display("[TB] randomized bursts");
        for (int t = 0; t < 6; t++) begin
            addrReadyMode = $urandom_range(0, 2);
            outReadyMode  = $urandom_range(0, 1);
            poolLat       = $urandom_range(0, 3);
            runBurst(GRP'(1 << $urandom_range(0, GRP - 1)), RP'($urandom_range(1, 15)),
                     $urandom_range(0, 4095), $urandom_range(0, 4095), $urandom_range(1, 12));
        end

        $display("[TB] reset mid-burst");
        addrReadyMode = 0; outReadyMode = 0; poolLat = 3;
        applyStimulus(3'b001, 4'b1111, 'h200, 1, 6);
        n = 0;
        while (popCount < 2 && n < 200) begin
            waitCycles(1);
            n++;
        end
        checkOutput("two_beats_before_reset", DW'(popCount >= 2), DW'(1'b1));
        rst_n       = 1'b0;
        burstActive = 1'b0;
        expAddr.delete();
        expData.delete();
        waitCycles(1);
        checkAllZero("mid_reset");
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        waitCycles(10);
        checkOutput("no_done_after_abort", DW'(doneCount - doneAtStart), DW'(0));
        checkOutput("late_data_no_err", DW'(err_o), DW'(1'b0));
        checkOutput("idle_after_reset", DW'(cmd_ready_o), DW'(1'b1));
        runBurst(3'b100, 4'b1100, 'h3F0, 5, 5);

        $display("[TB] zero length and spurious data");
        applyStimulus(3'b010, 4'b1111, 'h050, 1, 0);
        waitCycles(1);
        checkOutput("zero_len_done", DW'(done_o), DW'(1'b1));
        checkOutput("zero_len_no_request", DW'(read_bank_en_o), '0);
        waitCycles(1);
        checkOutput("zero_len_done_single", DW'(done_o), DW'(1'b0));
        checkOutput("zero_len_ready", DW'(cmd_ready_o), DW'(1'b1));
        checkOutput("zero_len_err", DW'(err_o), DW'(1'b0));
        burstActive = 1'b0;
        spuriousReq = 1'b1;
        waitCycles(3);
        checkOutput("spurious_err", DW'(err_o), DW'(1'b1));
        checkOutput("spurious_dropped", DW'(out_valid_o), DW'(1'b0));
        waitCycles(5);
        checkOutput("err_sticky", DW'(err_o), DW'(1'b1));

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
